// File: rtl/branch_condition_unit.sv
// Decode-stage branch resolution: evaluates the condition field against NZCV and
// detects B/BL encodings. It produces a registered take-branch decision, a x4
// sign-extended offset, and the target address.
// Ports: clk, Reset (sync, active-high); in_valid, instr[31:0], pc_in[31:0],
//   cc_in[3:0] {N,Z,C,V}, s_update -> out_valid, asserted, b_instr, b_link,
//   choose_ta_r_nop, sex4_out[31:0], target_addr[31:0]; all outputs 1-cycle registered.
// Build option: COND_NV_NEVER_EN makes condition 1111 evaluate false (default: true).
module branch_condition_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic [3:0]  cc_in,
  input  logic        s_update,
  output logic        out_valid,
  output logic        asserted,
  output logic        b_instr,
  output logic        b_link,
  output logic        choose_ta_r_nop,
  output logic [31:0] sex4_out,
  output logic [31:0] target_addr
);

  logic [3:0]  r_cc;
  logic [3:0]  w_cc;
  logic        w_n, w_z, w_c, w_v;
  logic        w_cond;
  logic        w_is_b;
  logic [31:0] w_sex4;

  // A same-cycle flag update is forwarded so the instruction sees the new flags
  assign w_cc   = s_update ? cc_in : r_cc;
  assign w_n    = w_cc[3];
  assign w_z    = w_cc[2];
  assign w_c    = w_cc[1];
  assign w_v    = w_cc[0];
  assign w_is_b = (instr[27:25] == 3'b101);
  assign w_sex4 = {{6{instr[23]}}, instr[23:0], 2'b00};

  always_comb begin
    w_cond = 1'b0;
    unique case (instr[31:28])
      4'h0: w_cond = w_z;
      4'h1: w_cond = ~w_z;
      4'h2: w_cond = w_c;
      4'h3: w_cond = ~w_c;
      4'h4: w_cond = w_n;
      4'h5: w_cond = ~w_n;
      4'h6: w_cond = w_v;
      4'h7: w_cond = ~w_v;
      4'h8: w_cond = w_c & ~w_z;
      4'h9: w_cond = ~w_c | w_z;
      4'hA: w_cond = (w_n == w_v);
      4'hB: w_cond = (w_n != w_v);
      4'hC: w_cond = ~w_z & (w_n == w_v);
      4'hD: w_cond = w_z | (w_n != w_v);
      4'hE: w_cond = 1'b1;
`ifdef COND_NV_NEVER_EN
      4'hF: w_cond = 1'b0;
`else
      4'hF: w_cond = 1'b1;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cc            <= 4'b0000;
      out_valid       <= 1'b0;
      asserted        <= 1'b0;
      b_instr         <= 1'b0;
      b_link          <= 1'b0;
      choose_ta_r_nop <= 1'b0;
      sex4_out        <= 32'd0;
      target_addr     <= 32'd0;
    end else begin
      if (s_update)
        r_cc <= cc_in;
      out_valid       <= in_valid;
      asserted        <= in_valid & w_cond;
      b_instr         <= in_valid & w_is_b;
      b_link          <= in_valid & w_is_b & instr[24];
      choose_ta_r_nop <= in_valid & w_is_b & w_cond;
      sex4_out        <= w_sex4;
      target_addr     <= pc_in + w_sex4;
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Self-checking bench for branch_condition_unit: directed cases, a full
// condition x flags sweep, and randomized traffic against a behavioural model.
module tb_branch_condition_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic [3:0]  cc_in = 4'd0;
  logic        s_update = 1'b0;
  logic        out_valid, asserted, b_instr, b_link, choose_ta_r_nop;
  logic [31:0] sex4_out, target_addr;

  int tests = 0;
  int fails = 0;
  logic [3:0] m_cc = 4'd0;

  branch_condition_unit dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .instr(instr),
    .pc_in(pc_in), .cc_in(cc_in), .s_update(s_update),
    .out_valid(out_valid), .asserted(asserted), .b_instr(b_instr),
    .b_link(b_link), .choose_ta_r_nop(choose_ta_r_nop),
    .sex4_out(sex4_out), .target_addr(target_addr)
  );

  always #5 clk = ~clk;

  // Reference condition evaluation from the mnemonic rules
  function automatic bit ref_cond(input int cond, input int f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return c && !z;
      9: return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: begin
`ifdef COND_NV_NEVER_EN
        return 0;
`else
        return 1;
`endif
      end
    endcase
  endfunction

  // Offset as a signed integer times four, wrapped to 32 bits
  function automatic logic [31:0] ref_off(input logic [31:0] ins);
    longint v;
    v = longint'(ins & 32'h00FF_FFFF);
    if (v >= 64'sd8388608) v = v - 64'sd16777216;
    return 32'(v * 4);
  endfunction

  task automatic drive(input bit rst, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [3:0] cc, input bit su);
    Reset = rst; in_valid = v; instr = ins; pc_in = pc; cc_in = cc; s_update = su;
    @(posedge clk);
    #1;
    if (rst) m_cc = 4'd0;
    else if (su) m_cc = cc;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'hEA00_0001, 32'h10, 4'hF, 1);
    tests++;
    if ({out_valid, asserted, b_instr, b_link, choose_ta_r_nop, sex4_out, target_addr} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ov=%b as=%b b=%b bl=%b ch=%b sx=%h ta=%h want all zero",
               out_valid, asserted, b_instr, b_link, choose_ta_r_nop, sex4_out, target_addr);
    end
    drive(0, 1, 32'h0A00_0000, 32'h0, 4'hF, 0);
    tests++;
    if (asserted !== 1'b0 || out_valid !== 1'b1 || choose_ta_r_nop !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags_eq: got as=%b ov=%b ch=%b want as=0 ov=1 ch=0",
               asserted, out_valid, choose_ta_r_nop);
    end
    drive(0, 1, 32'h1A00_0000, 32'h0, 4'hF, 0);
    tests++;
    if (asserted !== 1'b1) begin
      fails++;
      $display("FAIL reset_flags_ne: got %b want 1", asserted);
    end
  endtask

  task automatic test_le_link();
    drive(0, 1, 32'hDB00_0001, 32'h100, 4'b0011, 1);
    tests++;
    if ({asserted, b_instr, b_link, choose_ta_r_nop} !== 4'b1111) begin
      fails++;
      $display("FAIL le_link_flags: got %b%b%b%b want 1111", asserted, b_instr, b_link, choose_ta_r_nop);
    end
    tests++;
    if (sex4_out !== 32'h4 || target_addr !== 32'h104) begin
      fails++;
      $display("FAIL le_link_addr: got sx=%h ta=%h want 00000004 00000104", sex4_out, target_addr);
    end
  endtask

  task automatic test_backward();
    drive(0, 1, 32'hEAFF_FFFE, 32'h8, 4'h0, 0);
    tests++;
    if (sex4_out !== 32'hFFFF_FFF8 || target_addr !== 32'h0 || choose_ta_r_nop !== 1'b1 || b_link !== 1'b0) begin
      fails++;
      $display("FAIL backward: got sx=%h ta=%h ch=%b bl=%b want fffffff8 00000000 1 0",
               sex4_out, target_addr, choose_ta_r_nop, b_link);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] ins, pc;
    logic [3:0] other;
    bit e;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        ins = {4'(c), 3'b101, 1'($urandom_range(1)), 24'($urandom)};
        pc = $urandom;
        e = ref_cond(c, f);
        drive(0, 1, ins, pc, 4'(f), 1);
        tests++;
        if (asserted !== e || choose_ta_r_nop !== e || target_addr !== pc + ref_off(ins)) begin
          fails++;
          $display("FAIL sweep_fwd c=%0d f=%0d: got as=%b ch=%b ta=%h want %b %b %h",
                   c, f, asserted, choose_ta_r_nop, target_addr, e, e, pc + ref_off(ins));
        end
        // Stored flags must be used when no update is presented
        other = 4'($urandom);
        drive(0, 1, ins, pc, other, 0);
        tests++;
        if (asserted !== e) begin
          fails++;
          $display("FAIL sweep_held c=%0d f=%0d: got %b want %b", c, f, asserted, e);
        end
      end
    end
  endtask

  task automatic test_nonbranch();
    drive(0, 1, 32'hE081_2003, 32'h40, 4'h0, 1);
    tests++;
    if (asserted !== 1'b1 || b_instr !== 1'b0 || b_link !== 1'b0 || choose_ta_r_nop !== 1'b0) begin
      fails++;
      $display("FAIL nonbranch: got as=%b b=%b bl=%b ch=%b want 1 0 0 0",
               asserted, b_instr, b_link, choose_ta_r_nop);
    end
  endtask

  task automatic test_nv_wrap();
    bit e;
`ifdef COND_NV_NEVER_EN
    e = 0;
`else
    e = 1;
`endif
    drive(0, 1, 32'hFA00_0000, 32'h200, 4'h0, 0);
    tests++;
    if (choose_ta_r_nop !== e || target_addr !== 32'h200) begin
      fails++;
      $display("FAIL nv_cond: got ch=%b ta=%h want %b 00000200", choose_ta_r_nop, target_addr, e);
    end
    drive(0, 1, 32'hEA00_0001, 32'hFFFF_FFFC, 4'h0, 0);
    tests++;
    if (target_addr !== 32'h0 || sex4_out !== 32'h4) begin
      fails++;
      $display("FAIL wrap: got ta=%h sx=%h want 00000000 00000004", target_addr, sex4_out);
    end
  endtask

  task automatic test_invalid();
    drive(0, 0, 32'hEB00_0010, 32'h0, 4'h0, 0);
    tests++;
    if ({out_valid, asserted, b_instr, b_link, choose_ta_r_nop} !== 5'b0) begin
      fails++;
      $display("FAIL invalid: got %b%b%b%b%b want 00000",
               out_valid, asserted, b_instr, b_link, choose_ta_r_nop);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, pc;
    logic [3:0] cc, eff;
    bit rst, v, su, ec, eb;
    logic [36:0] got, want;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(19) == 0);
      v = ($urandom_range(3) != 0);
      su = $urandom_range(1);
      ins = $urandom;
      if ($urandom_range(1)) ins[27:25] = 3'b101;
      pc = $urandom;
      cc = 4'($urandom);
      eff = su ? cc : m_cc;
      ec = ref_cond(int'(ins[31:28]), int'(eff));
      eb = (ins[27:25] == 3'b101);
      if (rst)
        want = '0;
      else
        want = {v, v && ec, v && eb, v && eb && ins[24], v && eb && ec, pc + ref_off(ins)};
      drive(rst, v, ins, pc, cc, su);
      got = {out_valid, asserted, b_instr, b_link, choose_ta_r_nop, target_addr};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL random i=%0d: got %h want %h (ins=%h cc=%h su=%b rst=%b)",
                 i, got, want, ins, cc, su, rst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_le_link();
    test_backward();
    test_sweep();
    test_nonbranch();
    test_nv_wrap();
    test_invalid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
